watchdog_rf_shutdown: RTL and testbench
=======================================

Name: watchdog_rf_shutdown

Overview:
- Sits directly downstream of watchdog_timer. Consumes its `triggered` and `warning` outputs and owns the gain applied to the AM carrier/modulator output.
- Ramps RF amplitude up and down in controlled steps, so no hard step reaches the PA, and attenuates the output while the watchdog warns.
- On a watchdog trip it forces a ramp to zero and latches a fault. The fault holds until software clears it and a cooldown period elapses.

Parameters:
- GAIN_W, 16, width of amplitude/gain words (unsigned).
- RAMP_STEP, 256, maximum gain change per clock cycle, during ramps and during tracking.
- WARN_SHIFT, 1, right-shift applied to the target gain while wd_warning=1.
- COOLDOWN_CYCLES, 1024, cycles spent in COOLDOWN before IDLE is re-entered; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wd_triggered  in  1  watchdog_timer `triggered` (level).
- wd_warning  in  1  watchdog_timer `warning` (level).
- tx_enable_req  in  1  host request to transmit (level).
- amplitude_in  in  GAIN_W  requested target gain, unsigned.
- clear_fault  in  1  single-cycle pulse from the register bank.
- gain_out  out  GAIN_W  registered gain applied to the modulator.
- rf_enable  out  1  PA enable; 1 in RAMP_UP, ACTIVE and RAMP_DOWN only.
- fault_latched  out  1  sticky watchdog-trip flag.
- state_out  out  3  encoded state for status readback.

Behaviour:
- State encoding: IDLE=0, RAMP_UP=1, ACTIVE=2, RAMP_DOWN=3, FAULT=4, COOLDOWN=5. Codes 6 and 7 recover to IDLE on the next cycle.
- Reset values: state=IDLE, gain_out=0, rf_enable=0, fault_latched=0, cooldown counter=0. Reset wins over every other input in the same cycle, including mid-ramp, where gain drops straight to 0.
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N, i.e. 1-cycle latency.
- Effective target: tgt = wd_warning ? (amplitude_in >> WARN_SHIFT) : amplitude_in, re-evaluated every cycle.
- Step rule for moving toward a destination d:
  - if |d - gain| <= RAMP_STEP, gain := d;
  - otherwise gain moves by RAMP_STEP toward d.
  - Arithmetic is GAIN_W+1 bits wide, so gain never wraps past 0 or 2^GAIN_W-1.
- IDLE: gain=0. If tx_enable_req=1 and wd_triggered=0 and fault_latched=0, go to RAMP_UP.
- RAMP_UP: step gain toward tgt. When gain==tgt after the update, go to ACTIVE.
- ACTIVE: step gain toward tgt each cycle (tracks amplitude_in and warning changes, rate-limited).
- RAMP_UP/ACTIVE exit on tx_enable_req=0: go to RAMP_DOWN.
- RAMP_DOWN: step gain toward 0. When gain reaches 0, go to FAULT if fault_latched=1, else IDLE. tx_enable_req reasserting during RAMP_DOWN is ignored until IDLE is reached.
- wd_triggered=1 in RAMP_UP, ACTIVE or RAMP_DOWN:
  - set fault_latched=1 the same cycle;
  - go to (or stay in) RAMP_DOWN.
  - Priority: wd_triggered > tx_enable_req > tgt change.
- wd_triggered=1 in IDLE: set fault_latched=1 and go directly to FAULT, since gain is already 0.
- FAULT: gain=0, rf_enable=0. If clear_fault=1 and wd_triggered=0, clear fault_latched, load the counter with COOLDOWN_CYCLES-1 and go to COOLDOWN. clear_fault while wd_triggered=1 is ignored.
- COOLDOWN: gain=0. The counter decrements each cycle; at 0, go to IDLE.
  - wd_triggered=1 during COOLDOWN sets fault_latched and returns to FAULT.
  - tx_enable_req is ignored in COOLDOWN.
- clear_fault in any state other than FAULT has no effect.
- Gain 0 with tgt 0 in RAMP_UP completes immediately: RAMP_UP lasts one cycle, then ACTIVE with gain 0 and rf_enable=1.

Test Plan:
- Normal ramp (RAMP_STEP=256):
  - Stimulus: rst for 2 cycles, then tx_enable_req=1, amplitude_in=1024.
  - Required: IDLE→RAMP_UP; gain_out reads 256, 512, 768, 1024 on successive cycles; then ACTIVE with rf_enable=1 throughout.
- Warning attenuation:
  - Stimulus: in ACTIVE at gain 1024, assert wd_warning.
  - Required: gain_out 768, then 512, then holds at 512.
  - Stimulus: deassert wd_warning.
  - Required: 768, then 1024.
- Watchdog trip:
  - Stimulus: in ACTIVE at 1000, pulse wd_triggered for 1 cycle.
  - Required: fault_latched=1 next cycle; gain_out 744, 488, 232, 0; then FAULT with rf_enable=0.
  - Stimulus: tx_enable_req held at 1 throughout.
  - Required: no restart.
- Fault clear and cooldown (COOLDOWN_CYCLES=4):
  - Stimulus: clear_fault while wd_triggered=1.
  - Required: stays in FAULT.
  - Stimulus: clear_fault with wd_triggered=0.
  - Required: COOLDOWN for exactly 4 cycles, then IDLE, then RAMP_UP the next cycle if tx_enable_req=1.
- Saturation edge:
  - Stimulus: amplitude_in=16'hFFFF, RAMP_STEP=256.
  - Required: final step lands exactly on 0xFFFF with no wrap; dropping tx_enable_req ramps down to exactly 0 with no underflow.
- Reset mid-ramp:
  - Stimulus: rst at gain 512 during RAMP_DOWN with fault_latched=1.
  - Required: next cycle state=IDLE, gain_out=0, fault_latched=0, rf_enable=0.

Source files
------------

// File: rtl/watchdog_rf_shutdown.sv
// Purpose : rate-limited RF gain control with watchdog-driven ramp-down, sticky fault and cooldown.
// Latency : 1 cycle from any input sample to gain_out / rf_enable / fault_latched / state_out.
// Backpr. : none; level inputs are consumed every cycle, clear_fault is a one-cycle pulse.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   wd_triggered        : watchdog trip level (forces ramp to zero, latches fault)
//   wd_warning          : watchdog warning level (target gain >> WARN_SHIFT)
//   tx_enable_req       : host transmit request level
//   amplitude_in        : requested target gain, unsigned
//   clear_fault         : register-bank pulse, acted on only in FAULT
//   gain_out            : registered gain applied to the modulator
//   rf_enable           : PA enable, high in RAMP_UP / ACTIVE / RAMP_DOWN
//   fault_latched       : sticky watchdog-trip flag
//   state_out           : encoded state (IDLE=0 .. COOLDOWN=5)
module watchdog_rf_shutdown #(
    parameter int GAIN_W          = 16,
    parameter int RAMP_STEP       = 256,
    parameter int WARN_SHIFT      = 1,
    parameter int COOLDOWN_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wd_triggered,
    input  logic              wd_warning,
    input  logic              tx_enable_req,
    input  logic [GAIN_W-1:0] amplitude_in,
    input  logic              clear_fault,
    output logic [GAIN_W-1:0] gain_out,
    output logic              rf_enable,
    output logic              fault_latched,
    output logic [2:0]        state_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        ACTIVE    = 3'd2,
        RAMP_DOWN = 3'd3,
        FAULT     = 3'd4,
        COOLDOWN  = 3'd5
    } state_t;

    localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
    // Step held one bit wider than the gain so a step >= 2^GAIN_W still compares correctly.
    localparam logic [GAIN_W:0]   STEP_X   = (GAIN_W+1)'(RAMP_STEP);
    localparam logic [GAIN_W-1:0] STEP_N   = STEP_X[GAIN_W-1:0];

    state_t            state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              fault_q, fault_d;
    logic              rf_enable_q, rf_enable_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAIN_W-1:0] tgt;

    // Move g toward d by at most RAMP_STEP. The far-step branch is only taken when
    // the distance exceeds the step, so g +/- STEP_N cannot pass d, 0 or full scale.
    function automatic logic [GAIN_W-1:0] step_to(input logic [GAIN_W-1:0] g,
                                                  input logic [GAIN_W-1:0] d);
        logic [GAIN_W:0] ge, de;
        logic [GAIN_W-1:0] res;
        ge = {1'b0, g};
        de = {1'b0, d};
        if (de >= ge) begin
            res = ((de - ge) <= STEP_X) ? d : (g + STEP_N);
        end else begin
            res = ((ge - de) <= STEP_X) ? d : (g - STEP_N);
        end
        return res;
    endfunction

    assign tgt = wd_warning ? (amplitude_in >> WARN_SHIFT) : amplitude_in;

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                gain_d = '0;
                if (wd_triggered) begin
                    // Gain is already zero, so skip the ramp entirely.
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else if (tx_enable_req && !fault_q) begin
                    state_d = RAMP_UP;
                end
            end
            RAMP_UP, ACTIVE: begin
                if (wd_triggered) begin
                    fault_d = 1'b1;
                    gain_d  = step_to(gain_q, '0);
                    state_d = RAMP_DOWN;
                end else if (!tx_enable_req) begin
                    gain_d  = step_to(gain_q, '0);
                    state_d = RAMP_DOWN;
                end else begin
                    gain_d = step_to(gain_q, tgt);
                    if (state_q == RAMP_UP && gain_d == tgt) begin
                        state_d = ACTIVE;
                    end
                end
            end
            RAMP_DOWN: begin
                if (wd_triggered) begin
                    fault_d = 1'b1;
                end
                gain_d = step_to(gain_q, '0);
                if (gain_d == '0) begin
                    state_d = fault_d ? FAULT : IDLE;
                end
            end
            FAULT: begin
                gain_d = '0;
                if (clear_fault && !wd_triggered) begin
                    fault_d = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: begin
                gain_d = '0;
                if (wd_triggered) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                // Unused codes 6/7 fall back to a safe, gain-zero IDLE.
                gain_d  = '0;
                state_d = IDLE;
            end
        endcase
        rf_enable_d = (state_d == RAMP_UP) || (state_d == ACTIVE) || (state_d == RAMP_DOWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gain_q      <= '0;
            fault_q     <= 1'b0;
            rf_enable_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            fault_q     <= fault_d;
            rf_enable_q <= rf_enable_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gain_out      = gain_q;
    assign rf_enable     = rf_enable_q;
    assign fault_latched = fault_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_watchdog_rf_shutdown.sv
module tb_watchdog_rf_shutdown;

    logic        clk = 1'b0;
    logic        rst;
    logic        wd_triggered;
    logic        wd_warning;
    logic        tx_enable_req;
    logic [15:0] amplitude_in;
    logic        clear_fault;
    logic [15:0] gain_out;
    logic        rf_enable;
    logic        fault_latched;
    logic [2:0]  state_out;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_ACT = 3'd2,
                           S_DOWN = 3'd3, S_FAULT = 3'd4, S_COOL = 3'd5;

    watchdog_rf_shutdown #(
        .GAIN_W(16), .RAMP_STEP(256), .WARN_SHIFT(1), .COOLDOWN_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .wd_triggered(wd_triggered), .wd_warning(wd_warning),
        .tx_enable_req(tx_enable_req), .amplitude_in(amplitude_in),
        .clear_fault(clear_fault), .gain_out(gain_out), .rf_enable(rf_enable),
        .fault_latched(fault_latched), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wd_triggered = 0; wd_warning = 0; tx_enable_req = 0;
        amplitude_in = 16'd0; clear_fault = 0;
        tick(); tick();
        checks++;
        if (state_out !== S_IDLE || gain_out !== 16'd0 || rf_enable !== 1'b0 || fault_latched !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d gain=%0d rf=%b fault=%b required 0 0 0 0",
                     state_out, gain_out, rf_enable, fault_latched);
        end
        rst = 1'b0;
    endtask

    task automatic test_normal_ramp();
        logic [15:0] exp_g [5] = '{16'd0, 16'd256, 16'd512, 16'd768, 16'd1024};
        logic [2:0]  exp_s [5] = '{S_UP, S_UP, S_UP, S_UP, S_ACT};
        tx_enable_req = 1'b1; amplitude_in = 16'd1024;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gain_out !== exp_g[i] || state_out !== exp_s[i] || rf_enable !== 1'b1) begin
                errors++;
                $display("FAIL ramp_up[%0d]: gain=%0d state=%0d rf=%b required %0d %0d 1",
                         i, gain_out, state_out, rf_enable, exp_g[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_warning();
        logic [15:0] exp_g [5] = '{16'd768, 16'd512, 16'd512, 16'd768, 16'd1024};
        for (int i = 0; i < 5; i++) begin
            wd_warning = (i < 3);
            tick();
            checks++;
            if (gain_out !== exp_g[i] || state_out !== S_ACT || rf_enable !== 1'b1) begin
                errors++;
                $display("FAIL warning[%0d]: gain=%0d state=%0d rf=%b required %0d 2 1",
                         i, gain_out, state_out, rf_enable, exp_g[i]);
            end
        end
        wd_warning = 1'b0;
    endtask

    task automatic test_trip();
        logic [15:0] exp_g [4] = '{16'd744, 16'd488, 16'd232, 16'd0};
        logic [2:0]  exp_s [4] = '{S_DOWN, S_DOWN, S_DOWN, S_FAULT};
        logic        exp_rf [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        amplitude_in = 16'd1000;
        tick();
        checks++;
        if (gain_out !== 16'd1000 || state_out !== S_ACT) begin
            errors++;
            $display("FAIL track_1000: gain=%0d state=%0d required 1000 2", gain_out, state_out);
        end
        wd_triggered = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            wd_triggered = 1'b0;
            checks++;
            if (gain_out !== exp_g[i] || state_out !== exp_s[i] || rf_enable !== exp_rf[i] ||
                fault_latched !== 1'b1) begin
                errors++;
                $display("FAIL trip[%0d]: gain=%0d state=%0d rf=%b fault=%b required %0d %0d %b 1",
                         i, gain_out, state_out, rf_enable, fault_latched, exp_g[i], exp_s[i], exp_rf[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (state_out !== S_FAULT || gain_out !== 16'd0 || rf_enable !== 1'b0) begin
                errors++;
                $display("FAIL no_restart[%0d]: state=%0d gain=%0d rf=%b required 4 0 0",
                         i, state_out, gain_out, rf_enable);
            end
        end
    endtask

    task automatic test_fault_clear();
        logic [2:0] exp_s [6] = '{S_COOL, S_COOL, S_COOL, S_COOL, S_IDLE, S_UP};
        wd_triggered = 1'b1; clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0; wd_triggered = 1'b0;
        checks++;
        if (state_out !== S_FAULT || fault_latched !== 1'b1) begin
            errors++;
            $display("FAIL clear_blocked: state=%0d fault=%b required 4 1", state_out, fault_latched);
        end
        tick();
        clear_fault = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            clear_fault = 1'b0;
            if (i == 4) amplitude_in = 16'd0;
            checks++;
            if (state_out !== exp_s[i] || gain_out !== 16'd0 || fault_latched !== 1'b0) begin
                errors++;
                $display("FAIL cooldown[%0d]: state=%0d gain=%0d fault=%b required %0d 0 0",
                         i, state_out, gain_out, fault_latched, exp_s[i]);
            end
        end
    endtask

    task automatic test_zero_target();
        tick();
        checks++;
        if (state_out !== S_ACT || gain_out !== 16'd0 || rf_enable !== 1'b1) begin
            errors++;
            $display("FAIL zero_target: state=%0d gain=%0d rf=%b required 2 0 1",
                     state_out, gain_out, rf_enable);
        end
    endtask

    task automatic test_saturation();
        int exp;
        int bad = 0;
        amplitude_in = 16'hFFFF;
        for (int k = 1; k <= 256; k++) begin
            tick();
            exp = (k * 256 > 65535) ? 65535 : k * 256;
            if (bad == 0 && (gain_out !== exp[15:0] || state_out !== S_ACT)) begin
                bad = 1;
                $display("FAIL sat_up step %0d: gain=%0h state=%0d required %0h 2", k, gain_out, state_out, exp);
            end
        end
        checks++;
        if (bad != 0 || gain_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_up_final: gain=%0h required ffff", gain_out);
        end
        tx_enable_req = 1'b0;
        bad = 0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            exp = (65535 - k * 256 > 0) ? 65535 - k * 256 : 0;
            if (bad == 0 && gain_out !== exp[15:0]) begin
                bad = 1;
                $display("FAIL sat_down step %0d: gain=%0h required %0h", k, gain_out, exp);
            end
        end
        checks++;
        if (bad != 0 || gain_out !== 16'd0 || state_out !== S_IDLE || rf_enable !== 1'b0) begin
            errors++;
            $display("FAIL sat_down_final: gain=%0h state=%0d rf=%b required 0 0 0",
                     gain_out, state_out, rf_enable);
        end
    endtask

    task automatic test_reset_mid_ramp();
        tx_enable_req = 1'b1; amplitude_in = 16'd1024;
        for (int i = 0; i < 5; i++) tick();
        wd_triggered = 1'b1;
        tick();
        wd_triggered = 1'b0;
        tick();
        checks++;
        if (gain_out !== 16'd512 || state_out !== S_DOWN || fault_latched !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: gain=%0d state=%0d fault=%b required 512 3 1",
                     gain_out, state_out, fault_latched);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; tx_enable_req = 1'b0;
        checks++;
        if (state_out !== S_IDLE || gain_out !== 16'd0 || fault_latched !== 1'b0 || rf_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ramp: state=%0d gain=%0d fault=%b rf=%b required 0 0 0 0",
                     state_out, gain_out, fault_latched, rf_enable);
        end
    endtask

    initial begin
        test_reset();
        test_normal_ramp();
        test_warning();
        test_trip();
        test_fault_clear();
        test_zero_target();
        test_saturation();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
